uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

Transmit-side control and datapath of the UART serializer, sitting directly upstream of the 4-input line multiplexer that drives the TX pin. It accepts a parallel byte from the bridge's APB-read/response path, serializes it LSB first, and computes the parity bit. It drives the mux select that chooses among start bit, stop/idle level, serial data and parity for each bit period. Bit periods are paced by an external one-cycle baud tick.

## Interface
- DATA_WIDTH, 8, payload bits per frame (≥2)
- CLK  in  1  single clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- TICK  in  1  baud enable, one-cycle pulse per bit period
- P_DATA  in  DATA_WIDTH  parallel payload, sampled only on accept
- DATA_VALID  in  1  level request; held high until DATA_ACK
- PAR_EN  in  1  1 = append parity bit; sampled on accept
- PAR_TYP  in  1  0 = even, 1 = odd; sampled on accept
- MUX_SEL  out  2  line mux select: 0 = start (IN0 tied 0), 1 = stop/idle (IN1 tied 1), 2 = SER_DATA, 3 = PAR_BIT
- SER_DATA  out  1  current data bit (shift register bit 0)
- PAR_BIT  out  1  parity bit of latched frame
- BUSY  out  1  high while a frame is in flight
- DATA_ACK  out  1  one-cycle pulse on the cycle after accept

## Operation
- States: IDLE, START, DATA, PARITY, STOP. All transitions except accept happen only on cycles with TICK=1; with TICK=0 every register holds.
- Accept condition: TICK=1 and DATA_VALID=1 and (state=IDLE or state=STOP). On accept: shift register ← P_DATA, bit counter ← 0, PAR_EN/PAR_TYP latched, PAR_BIT ← XOR-reduce(P_DATA) XOR PAR_TYP, DATA_ACK ← 1 next cycle, state ← START.
- IDLE: no accept on tick → remain IDLE.
- START on tick → DATA.
- DATA on tick: if counter = DATA_WIDTH−1 → PARITY when latched PAR_EN=1, else STOP; otherwise shift register right by 1 (LSB first), counter +1.
- PARITY on tick → STOP.
- STOP on tick: accept if DATA_VALID (back-to-back, no idle bit), else → IDLE.
- Moore decode of state register: IDLE/STOP → MUX_SEL=1, START → 0, DATA → 2, PARITY → 3.
- BUSY = 1 in START, DATA, PARITY, STOP; 0 in IDLE.
- Counter width $clog2(DATA_WIDTH); never exceeds DATA_WIDTH−1.
- P_DATA/PAR_EN/PAR_TYP changes after accept have no effect on the frame in flight.

## Timing
- Reset (RST=1 at an edge, any state, including mid-frame): next cycle state=IDLE, MUX_SEL=2'b01, SER_DATA=0, PAR_BIT=0, BUSY=0, DATA_ACK=0, counter=0. Reset wins over simultaneous TICK/DATA_VALID.
- Accept at edge n → cycle n+1: MUX_SEL=0, BUSY=1, DATA_ACK=1 (for exactly one cycle).
- Each bit occupies exactly one tick period (tick edge to next tick edge); frame = 1 + DATA_WIDTH + PAR_EN + 1 tick periods.
- DATA_VALID seen without TICK is not accepted; requester must hold it. DATA_VALID during START/DATA/PARITY is ignored until STOP's tick.
- Back-to-back: STOP tick with DATA_VALID=1 → next cycle MUX_SEL=0; line shows exactly one stop bit between frames.
- All outputs registered or decoded from registers only; no combinational input-to-output path.

## Test plan
- Reset: assert RST mid-DATA of a 0xA5 frame → next cycle MUX_SEL=1, BUSY=0, DATA_ACK=0, SER_DATA=0; no further transitions until a new accept.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, tick every 4 cycles → line (mux output) 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each held 4 cycles; DATA_ACK single pulse; BUSY high 11 tick periods.
- Odd parity: P_DATA=0x03, PAR_EN=1, PAR_TYP=1 → PAR_BIT=1, MUX_SEL sequence 0, 2×8, 3, 1.
- No parity: P_DATA=0x55, PAR_EN=0 → line 0,1,0,1,0,1,0,1,0,1; MUX_SEL never 3; frame 10 tick periods.
- Back-to-back: DATA_VALID held with 0x12 then 0x34 → STOP tick of frame 1 goes straight to START; exactly one stop bit; two DATA_ACK pulses; BUSY never drops between frames.
- Tick stall: hold TICK=0 for 50 cycles mid-DATA → MUX_SEL, SER_DATA, counter unchanged; DATA_VALID high in IDLE without TICK → no accept, BUSY=0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a parallel byte, serializes it LSB first with
// optional parity, and drives the line-mux select once per baud tick.
module uart_tx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [1:0]            mux_sel,
   output logic                  ser_data,
   output logic                  par_bit,
   output logic                  busy,
   output logic                  data_ack
);

   localparam int unsigned   CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   localparam logic [1:0] MUX_START  = 2'd0;
   localparam logic [1:0] MUX_STOP   = 2'd1;
   localparam logic [1:0] MUX_DATA   = 2'd2;
   localparam logic [1:0] MUX_PARITY = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  par_en_q, par_en_nxt;
   logic                  par_bit_nxt;
   logic                  ack_nxt;
   logic [1:0]            mux_nxt;
   logic                  busy_nxt;

   assign ser_data = shreg[0];

   // State and datapath registers; mux_sel/busy are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         shreg    <= '0;
         cnt      <= '0;
         par_en_q <= 1'b0;
         par_bit  <= 1'b0;
         data_ack <= 1'b0;
         mux_sel  <= MUX_STOP;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         shreg    <= shreg_nxt;
         cnt      <= cnt_nxt;
         par_en_q <= par_en_nxt;
         par_bit  <= par_bit_nxt;
         data_ack <= ack_nxt;
         mux_sel  <= mux_nxt;
         busy     <= busy_nxt;
      end
   end

   // Next-state and datapath update; everything holds on non-tick cycles.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      cnt_nxt     = cnt;
      par_en_nxt  = par_en_q;
      par_bit_nxt = par_bit;
      ack_nxt     = 1'b0;

      if (tick) begin
         case (state)
            S_IDLE, S_STOP: begin
               if (data_valid) begin
                  state_nxt   = S_START;
                  shreg_nxt   = p_data;
                  cnt_nxt     = '0;
                  par_en_nxt  = par_en;
                  par_bit_nxt = (^p_data) ^ par_typ;
                  ack_nxt     = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            S_START: state_nxt = S_DATA;
            S_DATA: begin
               if (cnt == LAST) begin
                  state_nxt = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  shreg_nxt = shreg >> 1;
                  cnt_nxt   = cnt + CW'(1);
               end
            end
            S_PARITY: state_nxt = S_STOP;
            default:  state_nxt = S_IDLE;
         endcase
      end

      case (state_nxt)
         S_START:  mux_nxt = MUX_START;
         S_DATA:   mux_nxt = MUX_DATA;
         S_PARITY: mux_nxt = MUX_PARITY;
         default:  mux_nxt = MUX_STOP;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl against a frame-schedule reference model:
// each accepted frame becomes a queue of expected bit periods consumed one per tick.
module tb_uart_tx_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst, tick, data_valid, par_en, par_typ;
   logic [W-1:0] p_data;
   logic [1:0]   mux_sel;
   logic         ser_data, par_bit, busy, data_ack;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .mux_sel    (mux_sel),
      .ser_data   (ser_data),
      .par_bit    (par_bit),
      .busy       (busy),
      .data_ack   (data_ack)
   );

   typedef struct {
      logic [W-1:0] d;
      logic         pe;
      logic         pt;
   } frame_t;

   typedef struct {
      logic [1:0] mux;
      logic       line;
   } period_t;

   frame_t  reqq[$];
   period_t pq[$];

   int   errors = 0;
   int   checks = 0;
   int   acks_seen = 0;
   int   frames_acc = 0;
   logic exp_ack = 1'b0;
   logic exp_par = 1'b0;
   logic ser_zero = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: on a tick, a pending request is taken when the line is idle or in its
   // final (stop) period; otherwise the current period simply ends.
   task automatic model_edge(input logic t, input logic r, input logic dv);
      frame_t f;
      logic   p;
      if (r) begin
         pq.delete();
         exp_ack  = 1'b0;
         exp_par  = 1'b0;
         ser_zero = 1'b1;
         return;
      end
      exp_ack = 1'b0;
      if (t) begin
         if (pq.size() <= 1 && dv) begin
            f = reqq.pop_front();
            p = (^f.d) ^ f.pt;
            pq.delete();
            pq.push_back('{2'd0, 1'b0});
            for (int i = 0; i < int'(W); i++) pq.push_back('{2'd2, f.d[i]});
            if (f.pe) pq.push_back('{2'd3, p});
            pq.push_back('{2'd1, 1'b1});
            exp_par  = p;
            exp_ack  = 1'b1;
            ser_zero = 1'b0;
            frames_acc++;
         end else if (pq.size() > 0) begin
            pq.delete(0);
         end
      end
   endtask

   task automatic check_outputs();
      logic [1:0] em;
      logic       el;
      logic       line;
      if (pq.size() == 0) begin
         em = 2'd1;
         el = 1'b1;
      end else begin
         em = pq[0].mux;
         el = pq[0].line;
      end
      case (mux_sel)
         2'd0:    line = 1'b0;
         2'd1:    line = 1'b1;
         2'd2:    line = ser_data;
         default: line = par_bit;
      endcase
      check("mux_sel", 32'(mux_sel), 32'(em));
      check("busy", 32'(busy), 32'(pq.size() != 0));
      check("data_ack", 32'(data_ack), 32'(exp_ack));
      check("par_bit", 32'(par_bit), 32'(exp_par));
      check("line", 32'(line), 32'(el));
      if (ser_zero) check("ser_data_after_reset", 32'(ser_data), 32'd0);
      else if (em == 2'd2) check("ser_data", 32'(ser_data), 32'(el));
      if (data_ack) acks_seen++;
   endtask

   task automatic run_cycle(input logic t, input logic r);
      logic dv;
      rst  = r;
      tick = t;
      if (reqq.size() > 0) begin
         data_valid = 1'b1;
         p_data     = reqq[0].d;
         par_en     = reqq[0].pe;
         par_typ    = reqq[0].pt;
      end else begin
         data_valid = 1'b0;
         p_data     = W'($urandom);
         par_en     = 1'($urandom);
         par_typ    = 1'($urandom);
      end
      dv = data_valid;
      @(posedge clk);
      model_edge(t, r, dv);
      #1;
      check_outputs();
   endtask

   task automatic ticks(input int n, input int per);
      for (int k = 0; k < n; k++) begin
         run_cycle(1'b1, 1'b0);
         for (int j = 1; j < per; j++) run_cycle(1'b0, 1'b0);
      end
   endtask

   initial begin
      frame_t f;
      rst        = 1'b1;
      tick       = 1'b0;
      data_valid = 1'b0;
      p_data     = '0;
      par_en     = 1'b0;
      par_typ    = 1'b0;

      run_cycle(1'b0, 1'b1);
      run_cycle(1'b0, 1'b1);
      ticks(3, 2);

      // Even parity, tick every 4 cycles
      reqq.push_back('{8'hA5, 1'b1, 1'b0});
      ticks(13, 4);

      // Odd parity
      reqq.push_back('{8'h03, 1'b1, 1'b1});
      ticks(12, 3);

      // No parity
      reqq.push_back('{8'h55, 1'b0, 1'b0});
      ticks(12, 2);

      // Back-to-back frames with request held
      reqq.push_back('{8'h12, 1'b1, 1'b0});
      reqq.push_back('{8'h34, 1'b0, 1'b1});
      ticks(25, 2);

      // Tick stall mid-data with a pending request
      reqq.push_back('{8'hC3, 1'b1, 1'b1});
      ticks(5, 1);
      reqq.push_back('{8'h81, 1'b0, 1'b0});
      for (int i = 0; i < 50; i++) run_cycle(1'b0, 1'b0);
      ticks(25, 3);

      // Request in idle without tick is not accepted
      reqq.push_back('{8'h5A, 1'b1, 1'b0});
      for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0);
      ticks(12, 2);

      // Reset mid-frame, colliding with tick and a pending request
      reqq.push_back('{8'hA5, 1'b1, 1'b0});
      reqq.push_back('{8'h0F, 1'b1, 1'b1});
      ticks(5, 2);
      run_cycle(1'b1, 1'b1);
      reqq.delete();
      ticks(6, 2);

      // Randomized traffic with varying tick spacing
      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            f.d  = W'($urandom);
            f.pe = 1'($urandom);
            f.pt = 1'($urandom);
            reqq.push_back(f);
         end
         ticks(int'($urandom_range(4, 30)), int'($urandom_range(1, 4)));
      end
      reqq.delete();
      ticks(15, 1);

      check("ack_count", 32'(acks_seen), 32'(frames_acc));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
